gain_coef_div: RTL
==================

# gain_coef_div

Sequential gain-coefficient calculator, the inverse of the gain multiplier. Given a sample `a` and a target magnitude `ref`, it computes `coef = ref / |a|` in the same unsigned fixed-point coefficient format that the multiplier consumes. It uses a bit-serial restoring divider with a `st`/`rdy` handshake and saturation. It sits in the AGC/normalizer path and feeds `coef` to the multiplier, so that the multiplier output magnitude approximately equals `ref`.

## Interface
- `A_WDT`, 16: sample word length. `a` is sfi(A_WDT, A_WDT-1); `ref` is ufi(A_WDT-1, A_WDT-1).
- `COEF_WDT`, 16: coefficient word length, format ufi(COEF_WDT, COEF_WDT/2). Must be even, max 32.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `st`  in  1  start strobe; sampled only in IDLE.
- `a`  in  A_WDT  signed sample (divisor); captured on accepted `st`.
- `ref`  in  A_WDT-1  unsigned target magnitude (dividend); captured on accepted `st`.
- `busy`  out  1  high from the cycle after an accepted `st` until `rdy` is asserted, inclusive.
- `rdy`  out  1  one-cycle pulse; `coef` and `sat` are valid in this cycle and then hold.
- `coef`  out  COEF_WDT  result, ufi(COEF_WDT, COEF_WDT/2).
- `sat`  out  1  result saturated (overflow or `a == 0`); updated together with `coef`.

## Operation
- Integer view, with Q = A_WDT-1+COEF_WDT/2:
  - `ra = |a|` as an A_WDT-bit unsigned value. The most negative `a` gives `ra = 2^(A_WDT-1)`, which is exact and does not wrap.
  - `r = ref`.
  - `q = floor(r * 2^(COEF_WDT/2) / ra)`, truncation toward zero. The fraction lengths of `a` and `ref` cancel.
- Divider: restoring, one quotient bit per cycle, MSB first.
  - Q quotient bits, with dividend `r << (COEF_WDT/2)`.
  - Partial remainder register is A_WDT+1 bits, wide enough for compare/subtract against `ra`.
- Saturation, applied in the DONE state:
  - If `ra == 0` or `q >= 2^COEF_WDT`: `coef = {COEF_WDT{1}}`, `sat = 1`.
  - Otherwise: `coef = q[COEF_WDT-1:0]`, `sat = 0`.
- The sign of `a` never affects `coef` (the coefficient is unsigned).
- FSM:
  - IDLE: on `st=1`, capture `ra`, `r`; clear quotient and remainder; set bit counter = Q-1; go to DIV.
  - DIV: shift in one dividend bit; if remainder ≥ `ra`, subtract and shift in quotient bit 1, else 0. Decrement the counter. After the bit with counter = 0, go to DONE.
  - DONE: register `coef`/`sat`, pulse `rdy`, return to IDLE.
- `st` in DIV or DONE is ignored, with no queuing. Inputs are not re-sampled during an operation.
- `st` in the same cycle `rdy` is high is ignored. The earliest next accept is the cycle after `rdy`.
- Reset (`reset=0`), at any time including mid-division:
  - state → IDLE;
  - `coef=0`, `sat=0`, `rdy=0`, `busy=0`;
  - internal registers cleared.
  - The first `st` sampled after release starts a fresh operation.

## Timing
- Accepted `st` in cycle 0 → DIV occupies cycles 1..Q → DONE in cycle Q+1. `rdy=1` during cycle Q+1 only.
- Latency `st` → `rdy` = Q+1 cycles (24 for defaults). Throughput is one result per Q+2 cycles.
- `busy`: high in cycles 1..Q+1, low in IDLE.
- `coef`/`sat` change only on the edge that enters the `rdy` cycle, and hold until the next result or reset.
- Result does not depend on input changes after cycle 0.

## Test plan
Defaults A_WDT=16, COEF_WDT=16 (Q=23).
- Unity gain: `ref=0x4000`, `a=0x4000` → `rdy` exactly 24 cycles after `st`; `coef=0x0100`, `sat=0`. Repeat with `a=0xC000` → same result.
- Fractional result and full-scale input:
  - `ref=0x2000`, `a=0x6000` → `coef=0x0055` (truncated 1/3×256), `sat=0`.
  - `ref=0x4000`, `a=0x8000` → `coef=0x0080`.
  - `ref=0`, `a=0x1234` → `coef=0x0000`.
- Saturation:
  - `ref=0x7FFF`, `a=0x0001` → `coef=0xFFFF`, `sat=1`.
  - `a=0x0000`, any `ref` → `coef=0xFFFF`, `sat=1`.
  - Boundary: `ref=0x0100`, `a=0x0001` → q=0x10000 → saturate. `ref=0x00FF`, `a=0x0001` → `coef=0xFF00`, `sat=0`.
- Handshake:
  - Pulse `st` again mid-DIV and on the `rdy` cycle with different operands → ignored; result still matches the first operands.
  - `st` held high continuously → a new operation every 25 cycles.
  - `busy` is high for exactly 24 cycles per operation.
- Reset: assert `reset=0` in cycle 10 of a division → outputs go to 0 asynchronously and `rdy` never pulses. After release, a new `st` gives the correct result 24 cycles later.
- Closed-loop randomized: random `a`, `ref` against the integer model. Then feed `a` and `coef` to the gain multiplier and check that |y| is within quantization of min(`ref`, full scale) whenever `sat=0`.

Source files
------------

// File: rtl/gain_coef_div.sv
// gain_coef_div: bit-serial restoring divider producing coef = ref_in / |a| with saturation
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   st     : start strobe, accepted only in IDLE
//   a      : signed sample sfi(A_WDT, A_WDT-1), divisor
//   ref_in : unsigned target magnitude ufi(A_WDT-1, A_WDT-1), dividend
//   busy   : operation in flight, from the cycle after accept through the rdy cycle
//   rdy    : one-cycle pulse, coef/sat valid from this cycle on
//   coef   : ufi(COEF_WDT, COEF_WDT/2) coefficient
//   sat    : coef saturated (overflow or a == 0)
module gain_coef_div #(
  parameter int A_WDT    = 16,
  parameter int COEF_WDT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st,
  input  logic [A_WDT-1:0]    a,
  input  logic [A_WDT-2:0]    ref_in,
  output logic                busy,
  output logic                rdy,
  output logic [COEF_WDT-1:0] coef,
  output logic                sat
);
  localparam int Q     = A_WDT - 1 + COEF_WDT / 2;
  localparam int CNT_W = $clog2(Q + 1);
  localparam int QX    = Q + COEF_WDT;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t              state_q, state_d;
  logic [A_WDT-1:0]    ra_q, ra_d, ra_in;
  logic [Q-1:0]        dvd_q, dvd_d, quo_n;
  logic [Q-2:0]        quo_q, quo_d;
  logic [A_WDT:0]      rem_q, rem_d, rem_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COEF_WDT-1:0] coef_q, coef_d;
  logic                sat_q, sat_d, rdy_q, rdy_d, busy_q, busy_d, ge;
  logic [QX-1:0]       qx;
  always_comb begin
    // two's-complement negation of the most negative a yields 2^(A_WDT-1) as unsigned, exactly
    ra_in   = a[A_WDT-1] ? -a : a;
    // remainder before the shift is below ra <= 2^(A_WDT-1), so the shift never loses a bit
    rem_s   = (rem_q << 1) | (A_WDT+1)'(dvd_q[Q-1]);
    ge      = rem_s >= {1'b0, ra_q};
    quo_n   = {quo_q, ge};
    qx      = QX'(quo_n);
    state_d = state_q;
    ra_d    = ra_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    coef_d  = coef_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: if (st) begin
        state_d = DIV;
        ra_d    = ra_in;
        dvd_d   = {ref_in, {(COEF_WDT/2){1'b0}}};
        quo_d   = '0;
        rem_d   = '0;
        cnt_d   = CNT_W'(Q - 1);
        busy_d  = 1'b1;
      end
      DIV: begin
        rem_d = ge ? rem_s - {1'b0, ra_q} : rem_s;
        quo_d = quo_n[Q-2:0];
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          sat_d   = (ra_q == '0) || (|qx[QX-1:COEF_WDT]);
          coef_d  = sat_d ? '1 : qx[COEF_WDT-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      coef_q  <= '0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
      sat_q   <= sat_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end
  assign busy = busy_q;
  assign rdy  = rdy_q;
  assign coef = coef_q;
  assign sat  = sat_q;
endmodule
